// File: rtl/rgbw_pkg.sv
// Shared types and constants for the RGBW multiplier-sharing logic.
package rgbw_pkg;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  // WAIT cycles allowed before the optional timeout fires
  localparam int MULT_TIMEOUT_CYC = 64;

  // Default requester count and operand width
  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 8;

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches upward from last+1
// (mod N_REQ) and returns the first requester with req high.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate (last itself) to the nearest (last+1),
  // so the nearest active requester is the final assignment and wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % N_REQ);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one sequential multiplier
// among N_REQ requesters, one multiplication in flight at a time.
// Optional feature: define MULT_ARB_TIMEOUT_EN to abort a WAIT that lasts
// MULT_TIMEOUT_CYC cycles with result 0 and a sticky err flag.
module mult_share_arbiter
  import rgbw_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] b_in,
  output logic [N_REQ-1:0]   ack,
  output logic [2*W-1:0]     result,
  output logic               busy,
  output logic               mult_ld,
  output logic [W-1:0]       mult_a,
  output logic [W-1:0]       mult_b,
  input  logic               mult_rdy,
  input  logic [2*W-1:0]     mult_res,
  output logic               err
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t              state, state_nxt;
  logic [IW-1:0]           last, grant, pick_idx;
  logic                    pick_vld;
  logic                    tmo_hit;
  logic [N_REQ-1:0][W-1:0] a_vec, b_vec;

  assign a_vec = a_in;
  assign b_vec = b_in;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req   (req),
    .last  (last),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

`ifdef MULT_ARB_TIMEOUT_EN
  logic [5:0] tmo_cnt;
  logic       err_q;

  // Count cycles spent in WAIT; cleared whenever we leave it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             tmo_cnt <= '0;
    else if (state == WAIT) tmo_cnt <= tmo_cnt + 6'd1;
    else                    tmo_cnt <= '0;
  end

  // A ready arriving on the last allowed cycle still wins over the timeout
  assign tmo_hit = (state == WAIT) && !mult_rdy &&
                   (tmo_cnt == 6'(MULT_TIMEOUT_CYC - 1));

  // Sticky error, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err_q <= 1'b0;
    else if (tmo_hit) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and state-decoded outputs; mult_rdy only matters in WAIT
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    mult_ld   = (state == LOAD);
    ack       = '0;
    case (state)
      IDLE: if (pick_vld) state_nxt = LOAD;
      LOAD: state_nxt = WAIT;
      WAIT: if (mult_rdy || tmo_hit) state_nxt = DONE;
      DONE: begin
        ack[grant] = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch winner and its operands in IDLE; capture the product in WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last   <= IW'(N_REQ - 1);
      grant  <= '0;
      mult_a <= '0;
      mult_b <= '0;
      result <= '0;
    end else begin
      if (state == IDLE && pick_vld) begin
        grant  <= pick_idx;
        last   <= pick_idx;
        mult_a <= a_vec[pick_idx];
        mult_b <= b_vec[pick_idx];
      end
      if (state == WAIT) begin
        if (mult_rdy)     result <= mult_res;
        else if (tmo_hit) result <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomised + directed bench for mult_share_arbiter with a behavioural
// multiplier and a transaction-level reference model.
module tb_mult_share_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TMO = 64;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b1;
  logic [N-1:0]        req   = '0;
  logic [N-1:0][W-1:0] a_arr = '0;
  logic [N-1:0][W-1:0] b_arr = '0;
  logic [N-1:0]        ack;
  logic [2*W-1:0]      result;
  logic                busy, mult_ld, err;
  logic [W-1:0]        mult_a, mult_b;
  logic                mult_rdy = 1'b0;
  logic [2*W-1:0]      mult_res = '0;

  int           checks = 0, errors = 0;
  int           lat    = 8;
  bit           stuck  = 1'b0;
  bit           rnd_en = 1'b0;
  bit           chk_on = 1'b0;
  logic [N-1:0] hold   = '0;

  always #5 clk = ~clk;

  mult_share_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .req      (req),
    .a_in     (a_arr),
    .b_in     (b_arr),
    .ack      (ack),
    .result   (result),
    .busy     (busy),
    .mult_ld  (mult_ld),
    .mult_a   (mult_a),
    .mult_b   (mult_b),
    .mult_rdy (mult_rdy),
    .mult_res (mult_res),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Sequential multiplier: rdy pulses so that WAIT lasts exactly lat cycles
  int mcnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 0; mult_rdy <= 1'b0; mult_res <= '0;
    end else begin
      mult_rdy <= 1'b0;
      if (mult_ld) begin
        mcnt     <= lat - 1;
        mult_res <= 16'(mult_a) * 16'(mult_b);
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1 && !stuck) mult_rdy <= 1'b1;
      end
    end
  end

  // Reference model: a transaction is a countdown of busy cycles
  // (LOAD, lat x WAIT, DONE); DONE is the last one (m_cnt == 1).
  int          m_cnt = 0, m_dur = 0, m_last = N - 1, m_win = 0;
  logic [15:0] m_res = '0, m_pend = '0;
  logic [7:0]  m_a = '0, m_b = '0;
  bit          m_tmo = 1'b0, m_err = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_last = N - 1; m_res = '0; m_err = 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 1) begin
        m_res = m_pend;
        if (m_tmo) m_err = 1'b1;
      end
    end else if (req != '0) begin
      m_win = -1;
      for (int k = 1; k <= N; k++)
        if (m_win < 0 && req[(m_last + k) % N]) m_win = (m_last + k) % N;
      m_last = m_win;
      m_a    = a_arr[m_win];
      m_b    = b_arr[m_win];
      m_tmo  = stuck;
      m_pend = stuck ? 16'h0 : 16'(m_a) * 16'(m_b);
      m_dur  = stuck ? TMO + 2 : lat + 2;
      m_cnt  = m_dur;
    end
  end

  // Cycle-by-cycle output check against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ack", 32'(ack), (m_cnt == 1) ? 32'(1 << m_win) : 32'h0);
      chk("busy", 32'(busy), 32'(m_cnt != 0));
      chk("mult_ld", 32'(mult_ld), 32'(m_cnt != 0 && m_cnt == m_dur));
      chk("result", 32'(result), 32'(m_res));
      chk("err", 32'(err), 32'(m_err));
      if (m_cnt != 0 && m_cnt == m_dur) begin
        chk("mult_a", 32'(mult_a), 32'(m_a));
        chk("mult_b", 32'(mult_b), 32'(m_b));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (ack[i] && !hold[i]) req[i] = 1'b0;
      else if (rnd_en && !req[i] && $urandom_range(0, 3) == 0) begin
        req[i]   = 1'b1;
        a_arr[i] = W'($urandom);
        b_arr[i] = W'($urandom);
      end
    end
  endtask

  // cyc = negedges after the call until ack is seen; idx = -1 on timeout
  task automatic wait_ack(output int idx, output int cyc);
    idx = -1; cyc = 0;
    for (int n = 1; n <= 200 && idx < 0; n++) begin
      step();
      cyc = n;
      for (int i = 0; i < N; i++) if (ack[i]) idx = i;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ld"}, 32'(mult_ld), 0);
    chk({tag, "_res"}, 32'(result), 0);
    chk({tag, "_a"}, 32'(mult_a), 0);
    chk({tag, "_b"}, 32'(mult_b), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  // Assert reset away from the edge, check async clear, release on a negedge
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero(tag);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (req == '0 && !busy) break;
      step();
    end
    chk("drain_idle", 32'({busy, req}), 0);
  endtask

  initial begin
    int idx, cyc;
    logic [15:0] exp;

    do_reset("rst0");

    // Single request: IDLE cycle is cycle 1, DONE must be cycle lat+3
    step();
    a_arr[2] = 8'h12; b_arr[2] = 8'h34; req[2] = 1'b1;
    wait_ack(idx, cyc);
    chk("t1_idx", idx, 2);
    chk("t1_lat", cyc + 1, lat + 3);
    chk("t1_res", 32'(result), 32'h03A8);
    repeat (2) step();
    chk("t1_idle", 32'(busy), 0);

    // All four held high from a fresh reset: 0,1,2,3,0
    do_reset("rst1");
    hold = '1;
    for (int i = 0; i < N; i++) begin a_arr[i] = W'(i + 1); b_arr[i] = 8'hFF; end
    req = '1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(idx, cyc);
      chk("t2_idx", idx, k % 4);
      chk("t2_res", 32'(result), ((k % 4) + 1) * 255);
    end
    hold = '0; req = '0;
    repeat (2) step();

    // Arrivals during WAIT of requester 1: 3 must beat 0
    a_arr[1] = 8'h21; b_arr[1] = 8'h03; req[1] = 1'b1;
    repeat (3) step();
    a_arr[3] = 8'h07; b_arr[3] = 8'h09; req[3] = 1'b1;
    a_arr[0] = 8'h05; b_arr[0] = 8'h06; req[0] = 1'b1;
    wait_ack(idx, cyc); chk("t3_first", idx, 1);
    wait_ack(idx, cyc); chk("t3_second", idx, 3);
    wait_ack(idx, cyc); chk("t3_third", idx, 0);
    step();

    // Held request 0 yields to the other pending requesters
    hold[0] = 1'b1;
    a_arr[0] = 8'h0B; b_arr[0] = 8'h0D; req[0] = 1'b1;
    repeat (3) step();
    a_arr[2] = 8'hC0; b_arr[2] = 8'h02; req[2] = 1'b1;
    a_arr[3] = 8'hFF; b_arr[3] = 8'hFF; req[3] = 1'b1;
    wait_ack(idx, cyc); chk("t4_a", idx, 0);
    wait_ack(idx, cyc); chk("t4_b", idx, 2);
    wait_ack(idx, cyc); chk("t4_c", idx, 3);
    hold[0] = 1'b0;
    wait_ack(idx, cyc); chk("t4_d", idx, 0);
    step();

    // Requester drops req and changes operands mid-transaction
    a_arr[1] = 8'hAB; b_arr[1] = 8'hCD; req[1] = 1'b1;
    exp = 16'(8'hAB) * 16'(8'hCD);
    repeat (3) step();
    req[1] = 1'b0; a_arr[1] = 8'h11; b_arr[1] = 8'h22;
    wait_ack(idx, cyc);
    chk("t5_idx", idx, 1);
    chk("t5_res", 32'(result), 32'(exp));
    step();

    // Reset in WAIT aborts; afterwards requester 0 wins the full tie
    a_arr[2] = 8'h09; b_arr[2] = 8'h09; req[2] = 1'b1;
    repeat (4) step();
    for (int i = 0; i < N; i++) begin a_arr[i] = W'(i + 2); b_arr[i] = W'(3 * i + 1); end
    req = '1;
    do_reset("rst2");
    for (int k = 0; k < N; k++) begin
      wait_ack(idx, cyc);
      chk("t6_idx", idx, k);
    end
    drain();

    // Random traffic with a short multiplier
    lat = 3;
    rnd_en = 1'b1;
    repeat (400) step();
    rnd_en = 1'b0;
    drain();
    lat = 8;

`ifdef MULT_ARB_TIMEOUT_EN
    // Stuck multiplier: ack after IDLE, LOAD, 64 WAIT, DONE with result 0
    step();
    stuck = 1'b1;
    a_arr[1] = 8'h03; b_arr[1] = 8'h04; req[1] = 1'b1;
    wait_ack(idx, cyc);
    stuck = 1'b0;
    chk("tmo_idx", idx, 1);
    chk("tmo_lat", cyc + 1, TMO + 3);
    chk("tmo_res", 32'(result), 0);
    chk("tmo_err", 32'(err), 1);
    step();
    a_arr[2] = 8'h05; b_arr[2] = 8'h05; req[2] = 1'b1;
    wait_ack(idx, cyc);
    chk("tmo_sticky", 32'(err), 1);
    chk("tmo_next_res", 32'(result), 25);
    do_reset("rst3");
`endif

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin scheduler that shares the single sequential 8x8 multiplier (`mult8x8`, ld/mult_rdy handshake) among several requesters: colour generator, brightness scaling and white mixing. Sits between the requesters and the multiplier. It owns the multiplier's `ld`, `a` and `b` inputs, and returns each 16-bit product to the requester that asked for it with a one-cycle acknowledge. Only one multiplication is in flight at a time.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `W`, default 8: operand width; product width is 2W.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: active-low, asynchronous reset.
- `req` in N_REQ: request per requester; held high until ack.
- `a_in` in N_REQ*W: operand A, requester i at bits [i*W +: W]; stable while req[i] is high.
- `b_in` in N_REQ*W: operand B, same packing as `a_in`.
- `ack` out N_REQ: one-cycle pulse to the granted requester; `result` is valid in that same cycle.
- `result` out 2W: last product; holds its value until the next ack.
- `busy` out 1: high in every state except IDLE.
- `mult_ld` out 1: load strobe to the multiplier.
- `mult_a`, `mult_b` out W: registered operands to the multiplier.
- `mult_rdy` in 1: multiplier done.
- `mult_res` in 2W: multiplier product.
- `err` out 1: timeout flag; tied to 0 when the timeout feature is not compiled in.

## Operation
- FSM states and transitions:
  - IDLE: if any `req` bit is high, go to LOAD.
  - LOAD: go to WAIT.
  - WAIT: if `mult_rdy` is high, go to DONE.
  - DONE: go to IDLE.
- Arbitration in IDLE:
  - Pick the first requester with `req` high, searching from `last+1` upward, modulo N_REQ.
  - Latch the winner's index into `grant`.
  - Register the winner's `a_in`/`b_in` into `mult_a`/`mult_b`.
  - Set `last` to `grant`.
- LOAD: `mult_ld` = 1 for exactly this one cycle.
- WAIT:
  - `mult_ld` = 0.
  - `mult_rdy` is sampled here only; it is ignored in all other states.
  - On `mult_rdy` = 1, capture `mult_res` into `result`.
- DONE:
  - `ack[grant]` = 1; all other `ack` bits stay 0.
  - The requester must drop `req` by the next edge. If it is still high in IDLE, it is treated as a new request and arbitrated normally.
- Requester drops `req` mid-transaction: the transaction still completes and `ack` still pulses. Operands were already latched in IDLE, so later changes to `a_in`/`b_in` have no effect.
- Arrival during a transaction: a `req` that rises while `busy` is high waits. It is considered at the next IDLE.
- Reset values (asynchronous assertion):
  - `state` = IDLE.
  - `last` = N_REQ-1, so requester 0 wins the first tie.
  - `grant` = 0.
  - `ack`, `result`, `mult_a`, `mult_b`, `mult_ld`, `busy`, `err` all 0.
- Reset mid-transaction aborts immediately with no ack. The multiplier is reset by the same signal.

## Timing
- Request latency: `req` is sampled high at edge k, giving LOAD in cycle k+1 and `mult_ld` high during k+1.
- Result latency: `mult_rdy` sampled at edge m, giving DONE in cycle m+1 with `ack` and `result` valid in m+1.
- Overhead: minimum 3 cycles per operation on top of the multiplier latency (IDLE, LOAD, DONE).
- Back-to-back throughput: one operation per (multiplier latency + 3) cycles.
- Fairness: with all requests held high, grants rotate 0,1,2,3,0,...; no requester waits more than N_REQ-1 transactions.

## Configuration
- `MULT_ARB_TIMEOUT_EN` defined:
  - A 6-bit counter runs in WAIT.
  - If `mult_rdy` has not arrived after 64 WAIT cycles, go to DONE with `result` = 0 and set `err` = 1.
  - `err` is sticky; only reset clears it.
- Not defined: no counter; WAIT waits indefinitely; `err` = 0.

## Structure
- Shared package `rgbw_pkg` holds:
  - The state typedef (IDLE, LOAD, WAIT, DONE).
  - `MULT_TIMEOUT_CYC` = 64.
  - Default `N_REQ` and `W`.
- One sub-module, `rr_pick`: combinational round-robin picker. Inputs are `req` and `last`; outputs are the index and a valid flag.

## Test plan
- Single request, default parameters, multiplier latency 8:
  - Stimulus: req[2]=1 with a=0x12, b=0x34.
  - Response: `mult_ld` high for one cycle; `ack[2]` pulses 11 cycles after req; `result` = 0x03A8; `busy` low afterwards.
- All four requests held high:
  - Stimulus: a_in[i]=i+1, b_in=0xFF.
  - Response: acks in order 0,1,2,3,0; results 0x00FF, 0x01FE, 0x02FD, 0x03FC.
- Request arrival during WAIT:
  - Stimulus: req[3] rises while requester 1 is in WAIT, `last` = 1.
  - Response: requester 3 is granted right after requester 1's ack, not requester 0.
- Reset mid-transaction:
  - Stimulus: `reset` driven low in WAIT.
  - Response: all outputs 0 asynchronously; no ack; after release, requester 0 wins a 0/1/2/3 tie.
- Held request:
  - Stimulus: req[0] kept high after its ack, with other requests pending.
  - Response: requester 0 is re-served only after the other pending requesters.
- Timeout, with `MULT_ARB_TIMEOUT_EN` defined:
  - Stimulus: `mult_rdy` stuck low.
  - Response: ack 67 cycles after req (IDLE, LOAD, 64 WAIT, DONE); `result` = 0; `err` = 1 and remains set until reset.
